uart_tx_ctrl: RTL

UART transmit controller: accepts one byte per request, serialises it as start bit, 8 data bits LSB-first, optional parity bit, and 1 or 2 stop bits on `tx`. It is the sequencer for the UART parity generator: it latches the frame configuration, feeds the generator, and decides when its result is driven on the line. It sits between the host-side register interface and the TX pin.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_ctrl_parity.sv | 22 ++
 rtl/uart_tx_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, TX state encoding and helpers.
package uart_pkg;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_ODD  = 2'b01;
  localparam logic [1:0] PARITY_EVEN = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } tx_state_e;

  // 2'b11 is treated like PARITY_NONE: no parity slot in the frame.
  function automatic logic parity_enabled(input logic [1:0] ptype);
    return (ptype == PARITY_ODD) || (ptype == PARITY_EVEN);
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_parity.sv
// Parity generator: combinational parity bit for a byte under the given encoding.
module Parity
  import uart_pkg::*;
(
  input  logic       reset_n,
  input  logic [7:0] data,
  input  logic [1:0] parity_type,
  output logic       parity_bit
);

  always_comb begin
    parity_bit = 1'b0;
    if (reset_n && (parity_type != PARITY_NONE)) begin
      case (parity_type)
        PARITY_ODD:  parity_bit = ~^data;
        PARITY_EVEN: parity_bit = ^data;
        default:     parity_bit = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start, 8 data bits LSB-first, optional parity, 1 or 2 stops.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       send,
  input  logic [7:0] data_in,
  input  logic [1:0] parity_type,
  input  logic       stop_bits,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  // Handshake: a request is taken on any edge where send=1 and busy=0 (state IDLE);
  // requests while busy are dropped, never queued. done pulses with busy falling.
  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    data_q;
  logic [1:0]    ptype_q;
  logic          stop2_q;
  logic          accept, bit_end, parity_bit;
  logic          tx_d, busy_d, done_d;

  assign accept  = (state_q == ST_IDLE) && send;
  assign bit_end = (cnt_q == CNT_MAX);

  Parity u_parity (
    .reset_n     (reset_n),
    .data        (data_q),
    .parity_type (ptype_q),
    .parity_bit  (parity_bit)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (send)    state_d = ST_START;
      ST_START:  if (bit_end) state_d = ST_DATA;
      ST_DATA:   if (bit_end && (idx_q == 3'd7))
                   state_d = parity_enabled(ptype_q) ? ST_PARITY : ST_STOP1;
      ST_PARITY: if (bit_end) state_d = ST_STOP1;
      ST_STOP1:  if (bit_end) state_d = stop2_q ? ST_STOP2 : ST_IDLE;
      ST_STOP2:  if (bit_end) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed for the coming state so the registered tx lines up with it.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg_d[0];
      ST_PARITY: tx_d = parity_bit;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx   <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      tx   <= tx_d;
      busy <= busy_d;
      done <= done_d;
    end
  end

  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    shreg_d = shreg_q;
    if ((state_q == ST_IDLE) || bit_end) cnt_d = '0;
    if (accept) begin
      shreg_d = data_in;
    end else if ((state_q == ST_DATA) && bit_end) begin
      shreg_d = {1'b0, shreg_q[7:1]};
      idx_d   = idx_q + 3'd1;
    end
    if (state_q != ST_DATA) idx_d = '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      ptype_q <= PARITY_NONE;
      stop2_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      if (accept) begin
        data_q  <= data_in;
        ptype_q <= parity_type;
        stop2_q <= stop_bits;
      end
    end
  end

endmodule
